// File: rtl/sha2_pkg.sv
// Shared SHA-2 message-schedule definitions: sigma constants and functions,
// the stream FSM encoding, and the fixed padding words for an 8-word digest.
package sha2_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam int S0_ROT_A_32 = 7;
    localparam int S0_ROT_B_32 = 18;
    localparam int S0_SHR_32   = 3;
    localparam int S1_ROT_A_32 = 17;
    localparam int S1_ROT_B_32 = 19;
    localparam int S1_SHR_32   = 10;

    localparam int S0_ROT_A_64 = 1;
    localparam int S0_ROT_B_64 = 8;
    localparam int S0_SHR_64   = 7;
    localparam int S1_ROT_A_64 = 19;
    localparam int S1_ROT_B_64 = 61;
    localparam int S1_SHR_64   = 6;

    localparam logic [31:0] PAD_W8_32  = 32'h8000_0000;
    localparam logic [31:0] PAD_W15_32 = 32'h0000_0100;
    localparam logic [63:0] PAD_W8_64  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] PAD_W15_64 = 64'h0000_0000_0000_0200;

    // Words are carried in 64-bit containers; 32-bit words live in the low half.
    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
        logic [31:0] lo;
        lo = x[31:0];
        if (w == 32)
            return {32'h0, (lo >> n) | (lo << (32 - n))};
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] shr(input logic [63:0] x, input int n, input int w);
        if (w == 32)
            return {32'h0, x[31:0] >> n};
        return x >> n;
    endfunction

    function automatic logic [63:0] s0(input logic [63:0] x, input int w);
        if (w == 32)
            return rotr(x, S0_ROT_A_32, 32) ^ rotr(x, S0_ROT_B_32, 32) ^ shr(x, S0_SHR_32, 32);
        return rotr(x, S0_ROT_A_64, 64) ^ rotr(x, S0_ROT_B_64, 64) ^ shr(x, S0_SHR_64, 64);
    endfunction

    function automatic logic [63:0] s1(input logic [63:0] x, input int w);
        if (w == 32)
            return rotr(x, S1_ROT_A_32, 32) ^ rotr(x, S1_ROT_B_32, 32) ^ shr(x, S1_SHR_32, 32);
        return rotr(x, S1_ROT_A_64, 64) ^ rotr(x, S1_ROT_B_64, 64) ^ shr(x, S1_SHR_64, 64);
    endfunction

    // Padding for words 8..15 of a block holding an 8-word digest.
    function automatic logic [63:0] pad_word(input int k, input int w);
        if (k == 8)
            return (w == 32) ? {32'h0, PAD_W8_32} : PAD_W8_64;
        if (k == 15)
            return (w == 32) ? {32'h0, PAD_W15_32} : PAD_W15_64;
        return 64'h0;
    endfunction

endpackage

// File: rtl/sha2_w_step.sv
// Combinational single-word schedule expander:
// new_w = s1(x14) + x9 + s0(x1) + x0, modulo 2^WORD_W.
module sha2_w_step
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] x0,
    input  logic [WORD_W-1:0] x1,
    input  logic [WORD_W-1:0] x9,
    input  logic [WORD_W-1:0] x14,
    output logic [WORD_W-1:0] new_w
);

    logic [63:0] sum;
    logic        unused_hi;

    assign sum       = s1(64'(x14), WORD_W) + 64'(x9) + s0(64'(x1), WORD_W) + 64'(x0);
    assign new_w     = sum[WORD_W-1:0];
    assign unused_hi = ^sum;

endmodule

// File: rtl/sha2_w_expander_pipe.sv
// SHA-2 message-schedule streamer: loads one 16-word block and emits
// W[0..ROUNDS-1], P words per beat. Optional feature: SHA2_W_AUTOPAD_EN.
module sha2_w_expander_pipe
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64,
    parameter int P      = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*WORD_W-1:0] block_in,
    input  logic                 pad_mode,
    output logic                 w_valid,
    input  logic                 w_ready,
    output logic [P*WORD_W-1:0]  w_out,
    output logic [6:0]           w_idx,
    output logic                 w_last,
    output logic                 busy
);

    generate
        if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word
            $error("sha2_w_expander_pipe: WORD_W must be 32 or 64");
        end
        if (!(P == 1 || P == 2 || P == 4) || (ROUNDS % P) != 0 || (16 % P) != 0) begin : g_bad_p
            $error("sha2_w_expander_pipe: illegal P for ROUNDS");
        end
        if (ROUNDS > 127 || ROUNDS < 16) begin : g_bad_rounds
            $error("sha2_w_expander_pipe: ROUNDS out of range");
        end
    endgenerate

    state_t state, state_nxt;

    // win[k] is W[w_idx + k]; the head word sits at index 0.
    logic [15:0][WORD_W-1:0] win;
    logic [15:0][WORD_W-1:0] load_w;
    logic [15:0][WORD_W-1:0] shifted;
    logic [P-1:0][WORD_W-1:0] new_w;

    logic accept;
    logic xfer;
    logic last_beat;

    assign accept    = (state == IDLE) && in_valid && !abort;
    assign xfer      = (state == STREAM) && w_ready && !abort;
    assign last_beat = (state == STREAM) && (w_idx == 7'(ROUNDS - P));

`ifdef SHA2_W_AUTOPAD_EN
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            load_w[k] = block_in[(15-k)*WORD_W +: WORD_W];
            if (pad_mode && k >= 8)
                load_w[k] = WORD_W'(pad_word(k, WORD_W));
        end
    end
`else
    logic unused_pad;
    assign unused_pad = pad_mode;

    always_comb begin
        for (int k = 0; k < 16; k++)
            load_w[k] = block_in[(15-k)*WORD_W +: WORD_W];
    end
`endif

    // Lane j needs x[14+j]; past the window edge that is a word produced by lane j-2.
    for (genvar j = 0; j < P; j++) begin : g_step
        logic [WORD_W-1:0] x14;
        if (j < 2) begin : g_win
            assign x14 = win[14+j];
        end else begin : g_chain
            assign x14 = new_w[j-2];
        end
        sha2_w_step #(.WORD_W(WORD_W)) u_step (
            .x0   (win[j]),
            .x1   (win[j+1]),
            .x9   (win[j+9]),
            .x14  (x14),
            .new_w(new_w[j])
        );
    end

    for (genvar k = 0; k < 16; k++) begin : g_shift
        if (k + P < 16) begin : g_keep
            assign shifted[k] = win[k+P];
        end else begin : g_new
            assign shifted[k] = new_w[k+P-16];
        end
    end

    for (genvar j = 0; j < P; j++) begin : g_out
        assign w_out[(P-1-j)*WORD_W +: WORD_W] = win[j];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        w_valid   = 1'b0;
        busy      = 1'b0;
        w_last    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept)
                    state_nxt = STREAM;
            end
            STREAM: begin
                w_valid = 1'b1;
                busy    = 1'b1;
                w_last  = last_beat;
                if (xfer && last_beat)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort)
            state_nxt = IDLE;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            win   <= '0;
            w_idx <= '0;
        end else if (abort) begin
            w_idx <= '0;
        end else if (accept) begin
            win   <= load_w;
            w_idx <= '0;
        end else if (xfer) begin
            win   <= shifted;
            w_idx <= w_idx + 7'(P);
        end
    end

endmodule

// File: tb/tb_sha2_w_expander_pipe.sv
// Bench for sha2_w_expander_pipe: three configurations (SHA-256 P=1, P=4,
// SHA-512 P=2) checked against a plain-arithmetic schedule model.
module tb_sha2_w_expander_pipe;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic abort = 1'b0;
    logic in_valid = 1'b0;
    logic pad_mode = 1'b0;
    logic w_ready = 1'b0;
    logic [511:0]  blk32 = '0;
    logic [1023:0] blk64 = '0;

    logic        ir1, v1, l1, b1;
    logic [31:0] o1;
    logic [6:0]  i1;
    logic        ir4, v4, l4, b4;
    logic [127:0] o4;
    logic [6:0]  i4;
    logic        ir5, v5, l5, b5;
    logic [127:0] o5;
    logic [6:0]  i5;

    sha2_w_expander_pipe #(.WORD_W(32), .ROUNDS(64), .P(1)) u_p1 (
        .CLK(CLK), .RST(RST), .abort(abort), .in_valid(in_valid), .in_ready(ir1),
        .block_in(blk32), .pad_mode(pad_mode), .w_valid(v1), .w_ready(w_ready),
        .w_out(o1), .w_idx(i1), .w_last(l1), .busy(b1));

    sha2_w_expander_pipe #(.WORD_W(32), .ROUNDS(64), .P(4)) u_p4 (
        .CLK(CLK), .RST(RST), .abort(abort), .in_valid(in_valid), .in_ready(ir4),
        .block_in(blk32), .pad_mode(pad_mode), .w_valid(v4), .w_ready(w_ready),
        .w_out(o4), .w_idx(i4), .w_last(l4), .busy(b4));

    sha2_w_expander_pipe #(.WORD_W(64), .ROUNDS(80), .P(2)) u_512 (
        .CLK(CLK), .RST(RST), .abort(abort), .in_valid(in_valid), .in_ready(ir5),
        .block_in(blk64), .pad_mode(pad_mode), .w_valid(v5), .w_ready(w_ready),
        .w_out(o5), .w_idx(i5), .w_last(l5), .busy(b5));

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [31:0] m32 [64];
    logic [63:0] m64 [80];
    logic [31:0] cap1 [64];
    logic [31:0] cap4 [64];
    logic [63:0] cap5 [80];

    int n1, n4, n5;
    bit st1, st4, st5;
    logic [31:0]  po1;
    logic [127:0] po4, po5;
    logic [6:0]   pi1, pi4, pi5;
    bit mon_en = 1'b0;

    typedef struct {
        int          sel;
        int          idx;
        logic [63:0] exp;
        string       nm;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] rr32(input logic [31:0] x, input int n);
        return 32'({x, x} >> n);
    endfunction
    function automatic logic [63:0] rr64(input logic [63:0] x, input int n);
        return 64'({x, x} >> n);
    endfunction
    function automatic logic [31:0] sg0_32(input logic [31:0] x);
        return rr32(x, 7) ^ rr32(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] sg1_32(input logic [31:0] x);
        return rr32(x, 17) ^ rr32(x, 19) ^ (x >> 10);
    endfunction
    function automatic logic [63:0] sg0_64(input logic [63:0] x);
        return rr64(x, 1) ^ rr64(x, 8) ^ (x >> 7);
    endfunction
    function automatic logic [63:0] sg1_64(input logic [63:0] x);
        return rr64(x, 19) ^ rr64(x, 61) ^ (x >> 6);
    endfunction

    // Reference schedule: the textbook recurrence over the whole array.
    task automatic build_model(input bit pm);
        for (int t = 0; t < 16; t++) begin
            m32[t] = blk32[(15-t)*32 +: 32];
            m64[t] = blk64[(15-t)*64 +: 64];
`ifdef SHA2_W_AUTOPAD_EN
            if (pm && t >= 8) begin
                m32[t] = (t == 8) ? 32'h8000_0000 : (t == 15) ? 32'h0000_0100 : 32'h0;
                m64[t] = (t == 8) ? 64'h8000_0000_0000_0000 : (t == 15) ? 64'h200 : 64'h0;
            end
`else
            if (pm) m32[t] = m32[t];
`endif
        end
        for (int t = 16; t < 64; t++)
            m32[t] = sg1_32(m32[t-2]) + m32[t-7] + sg0_32(m32[t-15]) + m32[t-16];
        for (int t = 16; t < 80; t++)
            m64[t] = sg1_64(m64[t-2]) + m64[t-7] + sg0_64(m64[t-15]) + m64[t-16];
    endtask

    always @(negedge CLK) begin
        if (mon_en && RST) begin
            if (v1) begin
                if (st1) begin
                    chk("stall_w_p1", 64'(o1), 64'(po1));
                    chk("stall_idx_p1", 64'(i1), 64'(pi1));
                end
                if (w_ready && !abort) begin
                    chk("beat_range_p1", 64'(n1 < 64), 64'd1);
                    if (n1 < 64) begin
                        chk("idx_p1", 64'(i1), 64'(n1));
                        chk("w_p1", 64'(o1), 64'(m32[n1]));
                        chk("last_p1", 64'(l1), 64'(n1 == 63));
                        cap1[n1] = o1;
                    end
                    n1++;
                end
                st1 = !w_ready && !abort;
                po1 = o1;
                pi1 = i1;
            end else st1 = 1'b0;

            if (v4) begin
                if (st4) begin
                    chk("stall_w_p4", o4[63:0], po4[63:0]);
                    chk("stall_idx_p4", 64'(i4), 64'(pi4));
                end
                if (w_ready && !abort) begin
                    chk("beat_range_p4", 64'(n4 < 16), 64'd1);
                    if (n4 < 16) begin
                        chk("idx_p4", 64'(i4), 64'(n4 * 4));
                        chk("last_p4", 64'(l4), 64'(n4 == 15));
                        for (int j = 0; j < 4; j++) begin
                            chk("w_p4", 64'(o4[(3-j)*32 +: 32]), 64'(m32[n4*4+j]));
                            cap4[n4*4+j] = o4[(3-j)*32 +: 32];
                        end
                    end
                    n4++;
                end
                st4 = !w_ready && !abort;
                po4 = o4;
                pi4 = i4;
            end else st4 = 1'b0;

            if (v5) begin
                if (st5) begin
                    chk("stall_w_512", o5[127:64], po5[127:64]);
                    chk("stall_idx_512", 64'(i5), 64'(pi5));
                end
                if (w_ready && !abort) begin
                    chk("beat_range_512", 64'(n5 < 40), 64'd1);
                    if (n5 < 40) begin
                        chk("idx_512", 64'(i5), 64'(n5 * 2));
                        chk("last_512", 64'(l5), 64'(n5 == 39));
                        for (int j = 0; j < 2; j++) begin
                            chk("w_512", o5[(1-j)*64 +: 64], m64[n5*2+j]);
                            cap5[n5*2+j] = o5[(1-j)*64 +: 64];
                        end
                    end
                    n5++;
                end
                st5 = !w_ready && !abort;
                po5 = o5;
                pi5 = i5;
            end else st5 = 1'b0;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start(input bit pm);
        build_model(pm);
        pad_mode = pm;
        n1 = 0; n4 = 0; n5 = 0;
        st1 = 0; st4 = 0; st5 = 0;
        mon_en = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("busy_after_accept", 64'(b1), 64'd1);
        chk("in_ready_in_stream", 64'(ir1), 64'd0);
        chk("first_idx", 64'(i1), 64'd0);
    endtask

    task automatic run_block(input bit bp, input bit pm);
        int cyc;
        int c1;
        start(pm);
        c1 = 0;
        for (cyc = 0; cyc < 2000 && (b1 || b4 || b5); cyc++) begin
            if (b1) c1++;
            w_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
        end
        chk("drain_timeout", 64'(b1 | b4 | b5), 64'd0);
        chk("beats_p1", 64'(n1), 64'd64);
        chk("beats_p4", 64'(n4), 64'd16);
        chk("beats_512", 64'(n5), 64'd40);
        if (!bp) chk("cycles_p1", 64'(c1), 64'd64);
        w_ready = 1'b0;
        chk("in_ready_after_block", 64'(ir1 & ir4 & ir5), 64'd1);
    endtask

    task automatic rand_blocks();
        for (int k = 0; k < 16; k++) begin
            blk32[k*32 +: 32] = $urandom;
            blk64[k*64 +: 64] = {$urandom, $urandom};
        end
    endtask

    initial begin
        int t;
        tbl[0] = '{0, 0,  64'h6162_6380, "abc_p1_w0"};
        tbl[1] = '{0, 15, 64'h0000_0018, "abc_p1_w15"};
        tbl[2] = '{0, 16, 64'h6162_6380, "abc_p1_w16"};
        tbl[3] = '{0, 17, 64'h000F_0000, "abc_p1_w17"};
        tbl[4] = '{1, 16, 64'h6162_6380, "abc_p4_w16"};
        tbl[5] = '{1, 17, 64'h000F_0000, "abc_p4_w17"};
        tbl[6] = '{2, 16, 64'h6162_6380_0000_0000, "abc_512_w16"};
        tbl[7] = '{2, 17, 64'h0003_0000_0000_00C0, "abc_512_w17"};

        #12;
        chk("rst_in_ready", 64'(ir1), 64'd1);
        chk("rst_w_valid", 64'(v1 | v4 | v5), 64'd0);
        chk("rst_busy", 64'(b1 | b4 | b5), 64'd0);
        chk("rst_w_idx", 64'(i1), 64'd0);
        chk("rst_w_last", 64'(l1 | l4 | l5), 64'd0);
        @(posedge CLK);
        #1 RST = 1'b1;
        tick();

        // SHA-256 and SHA-512 "abc" blocks
        blk32 = {32'h6162_6380, 448'h0, 32'h0000_0018};
        blk64 = {64'h6162_6380_0000_0000, 896'h0, 64'h18};
        run_block(1'b0, 1'b0);
        for (int v = 0; v < 8; v++) begin
            logic [63:0] got;
            got = (tbl[v].sel == 0) ? 64'(cap1[tbl[v].idx]) :
                  (tbl[v].sel == 1) ? 64'(cap4[tbl[v].idx]) : cap5[tbl[v].idx];
            chk(tbl[v].nm, got, tbl[v].exp);
        end

        for (int r = 0; r < 3; r++) begin
            rand_blocks();
            run_block(1'b1, 1'b0);
        end

`ifdef SHA2_W_AUTOPAD_EN
        rand_blocks();
        run_block(1'b1, 1'b1);
        chk("pad_w8", 64'(cap1[8]), 64'h8000_0000);
        chk("pad_w15", 64'(cap1[15]), 64'h0000_0100);
        for (int k = 9; k < 15; k++) chk("pad_zero", 64'(cap1[k]), 64'h0);
        chk("pad_512_w15", cap5[15], 64'h200);
        pad_mode = 1'b0;
`endif

        // abort at w_idx == 20
        rand_blocks();
        start(1'b0);
        w_ready = 1'b1;
        for (t = 0; t < 100 && i1 != 7'd20; t++) tick();
        chk("abort_reach_idx20", 64'(i1), 64'd20);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        w_ready = 1'b0;
        chk("abort_w_valid", 64'(v1 | v4 | v5), 64'd0);
        chk("abort_w_idx", 64'(i1), 64'd0);
        chk("abort_busy", 64'(b1), 64'd0);
        abort = 1'b1;
        in_valid = 1'b1;
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        chk("abort_blocks_accept", 64'(b1 | b4 | b5), 64'd0);
        rand_blocks();
        run_block(1'b0, 1'b0);

        // reset pulsed mid-stream
        rand_blocks();
        start(1'b0);
        w_ready = 1'b1;
        repeat (5) tick();
        #2 RST = 1'b0;
        #1;
        chk("mid_rst_w_valid", 64'(v1 | v4 | v5), 64'd0);
        chk("mid_rst_busy", 64'(b1), 64'd0);
        chk("mid_rst_idx", 64'(i1), 64'd0);
        chk("mid_rst_in_ready", 64'(ir1), 64'd1);
        w_ready = 1'b0;
        @(posedge CLK);
        #1 RST = 1'b1;
        tick();
        rand_blocks();
        run_block(1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
